sram_ctrl_param: RTL and testbench
==================================

# sram_ctrl_param

Parametrised byte-wide host-to-SRAM controller for 16-bit asynchronous SRAM parts with byte-lane enables (IS61/CY7-class). It converts a valid/ready single-byte request from the system bus into timed CE/OE/WE/UB/LB strobe sequences and returns read data or a write acknowledge through a one-cycle response pulse. Wait states, address width and read-to-write turnaround are configurable, so one block serves all board SRAM speed grades.

## Interface
- ADDR_W, 19, host byte-address width; SRAM word address is ADDR_W-1 bits
- RD_WAIT, 2, cycles OE is held low per read (legal range 1..15)
- WR_WAIT, 2, cycles WE is held low per write (legal range 1..15)
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- req_valid_in  input  1  request present
- req_ready_out  output  1  controller can accept a request
- req_rw_in  input  1  1 = read, 0 = write
- req_addr_in  input  ADDR_W  byte address
- req_wdata_in  input  8  write byte
- rsp_valid_out  output  1  one-cycle pulse: access complete
- rsp_rdata_out  output  8  read byte; valid while rsp_valid_out = 1, held until next read completes
- sram_addr_out  output  ADDR_W-1  word address (req_addr_in[ADDR_W-1:1])
- sram_data_io  inout  16  SRAM data bus
- sram_ce_n_out, sram_oe_n_out, sram_we_n_out  output  1 each  active-low strobes
- sram_lb_n_out, sram_ub_n_out  output  1 each  active-low byte-lane enables

## Operation
- States: IDLE, SETUP, READ, WRITE, HOLD, TURN (TURN exists only with the macro).
- IDLE: req_ready_out = 1, all strobes and lane enables high, bus released (Z). Handshake completes when req_valid_in and req_ready_out are both 1 at a rising edge; rw, addr and wdata are registered at that edge and may change afterwards.
- Lane select: addr[0] = 0 selects lower byte (lb_n = 0, data[7:0]); addr[0] = 1 selects upper byte (ub_n = 0, data[15:8]). Only the addressed lane is enabled, for reads and writes alike. On writes the unselected byte is driven 0x00.
- SETUP (1 cycle): address and lane enables valid, ce_n = 0, oe_n = we_n = 1; on writes the bus is driven.
- READ (RD_WAIT cycles): ce_n = 0, oe_n = 0. On the edge ending the last READ cycle, the selected byte is captured into rsp_rdata_out, rsp_valid_out is set, and the state moves to IDLE (or to TURN).
- WRITE (WR_WAIT cycles): ce_n = 0, we_n = 0, bus driven. The state then moves to HOLD.
- HOLD (1 cycle): we_n = 1, ce_n = 0, bus and address still driven for data hold time. The edge ending HOLD sets rsp_valid_out and moves to IDLE.
- The bus is driven only in SETUP-of-write, WRITE and HOLD; it is Z in every other state.
- A 4-bit down-counter times READ and WRITE; it is loaded with the wait value minus 1 on entry.
- Reset (asynchronous, at any time including mid-access):
  - state = IDLE; ce_n, oe_n, we_n, lb_n and ub_n all = 1; sram_addr_out = 0; bus = Z.
  - rsp_valid_out = 0; rsp_rdata_out = 0x00; req_ready_out = 1 once reset is released.
  - Any in-flight access is dropped and produces no response.

## Timing
- Acceptance edge is T0.
- Read: rsp_valid_out is high in the cycle after edge T0+1+RD_WAIT. With defaults, the read takes 3 cycles.
- Write: rsp_valid_out is high in the cycle after edge T0+2+WR_WAIT. With defaults, the write takes 4 cycles.
- Without the macro, req_ready_out returns to 1 in the same cycle as rsp_valid_out. Back-to-back requests are therefore accepted on the response cycle, with no idle gap.
- All SRAM pins are registered outputs, so there are no combinational paths from host inputs to pins.
- rsp_valid_out is never high for more than one consecutive cycle per access.

## Configuration
- SRAM_CTRL_TURNAROUND_EN defined:
  - Every read is followed by one TURN cycle before IDLE: strobes high, bus Z, req_ready_out = 0.
  - rsp_valid_out timing is unchanged; it is asserted on entry to TURN.
  - The next acceptance therefore occurs at least 1 cycle after the read response, guaranteeing bus-contention-free read-to-write turnaround.
- Not defined: the TURN state is absent and reads return directly to IDLE.

## Test plan
- Reset, then write addr 0x00004 data 0xA5: SETUP shows lb_n = 0, ub_n = 1, bus = 0x00A5. we_n is low for 2 cycles, followed by HOLD. rsp_valid_out pulses 4 cycles after acceptance.
- Write addr 0x00005 data 0x3C, then read 0x00005: the write shows ub_n = 0 with bus = 0x3C00. The read returns rsp_rdata_out = 0x3C, 3 cycles after its acceptance.
- Back-to-back reads of 0x00004 and 0x00005 with req_valid_in held high: the second request is accepted on the first rsp_valid cycle, and responses return 0xA5 then 0x3C.
- With RD_WAIT = 4 and WR_WAIT = 1: oe_n is low for exactly 4 cycles and we_n is low for exactly 1 cycle.
- Assert rst_in low during WRITE: the pins return to their idle values asynchronously, the bus goes Z, no rsp_valid is produced, and req_ready_out = 1 after release.
- With SRAM_CTRL_TURNAROUND_EN, issue a read then a write: req_ready_out is 0 for 1 cycle after the read response. The bus is not driven until the SETUP of the write.

Source files
------------

// File: rtl/sram_ctrl_param_if.sv
// Host request/response bus for sram_ctrl_param.
//   req_valid_in/req_ready_out : request handshake (host -> controller)
//   req_rw_in                  : 1 = read, 0 = write
//   req_addr_in                : byte address, ADDR_W bits
//   req_wdata_in               : write byte
//   rsp_valid_out              : one-cycle completion pulse
//   rsp_rdata_out              : read byte, held until the next read completes
`timescale 1ns/1ps
interface sram_ctrl_param_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              req_valid_in;
    logic              req_ready_out;
    logic              req_rw_in;
    logic [ADDR_W-1:0] req_addr_in;
    logic [7:0]        req_wdata_in;
    logic              rsp_valid_out;
    logic [7:0]        rsp_rdata_out;

    modport master (
        output req_valid_in, req_rw_in, req_addr_in, req_wdata_in,
        input  req_ready_out, rsp_valid_out, rsp_rdata_out
    );

    modport slave (
        input  req_valid_in, req_rw_in, req_addr_in, req_wdata_in,
        output req_ready_out, rsp_valid_out, rsp_rdata_out
    );
endinterface

// File: rtl/sram_ctrl_param.sv
// Byte-wide host-to-SRAM controller for 16-bit asynchronous SRAM with byte lanes.
// Turns one accepted byte request into a SETUP/READ or SETUP/WRITE/HOLD strobe
// sequence and reports completion with a one-cycle response pulse.
// Ports:
//   clk_in, rst_in     : clock, asynchronous active-low reset
//   host               : request/response bus (sram_ctrl_param_if.slave)
//   sram_addr_out      : SRAM word address (byte address >> 1)
//   sram_data_io       : 16-bit bidirectional SRAM data bus
//   sram_*_n_out       : active-low chip/output/write enables and byte lanes
// Optional feature: define SRAM_CTRL_TURNAROUND_EN to insert one TURN cycle
// after every read (ready held low) before the next request is accepted.
`timescale 1ns/1ps
module sram_ctrl_param #(
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    sram_ctrl_param_if.slave    host,
    output logic [ADDR_W-2:0]   sram_addr_out,
    inout  wire  [15:0]         sram_data_io,
    output logic                sram_ce_n_out,
    output logic                sram_oe_n_out,
    output logic                sram_we_n_out,
    output logic                sram_lb_n_out,
    output logic                sram_ub_n_out
);
    localparam int unsigned CNT_W = 4;

`ifdef SRAM_CTRL_TURNAROUND_EN
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_READ, S_WRITE, S_HOLD, S_TURN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_READ, S_WRITE, S_HOLD} state_t;
`endif

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               rd_q;       // current access is a read
    logic               lane_q;     // 1 = upper byte lane
    logic               drive_q;    // controller owns the data bus
    logic [15:0]        dout_q;

    // Bus is driven only while a write is in SETUP, WRITE or HOLD.
    assign sram_data_io = drive_q ? dout_q : 16'hzzzz;

    // Access sequencer; every pin and response output is registered here.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state               <= S_IDLE;
            wait_cnt            <= '0;
            rd_q                <= 1'b0;
            lane_q              <= 1'b0;
            drive_q             <= 1'b0;
            dout_q              <= '0;
            sram_addr_out       <= '0;
            sram_ce_n_out       <= 1'b1;
            sram_oe_n_out       <= 1'b1;
            sram_we_n_out       <= 1'b1;
            sram_lb_n_out       <= 1'b1;
            sram_ub_n_out       <= 1'b1;
            host.req_ready_out  <= 1'b1;
            host.rsp_valid_out  <= 1'b0;
            host.rsp_rdata_out  <= '0;
        end else begin
            host.rsp_valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (host.req_valid_in && host.req_ready_out) begin
                        rd_q               <= host.req_rw_in;
                        lane_q             <= host.req_addr_in[0];
                        sram_addr_out      <= host.req_addr_in[ADDR_W-1:1];
                        sram_ce_n_out      <= 1'b0;
                        sram_lb_n_out      <= host.req_addr_in[0];
                        sram_ub_n_out      <= !host.req_addr_in[0];
                        // Unselected lane carries 0x00; its enable stays high.
                        dout_q             <= host.req_addr_in[0] ? {host.req_wdata_in, 8'h00}
                                                                  : {8'h00, host.req_wdata_in};
                        drive_q            <= !host.req_rw_in;
                        host.req_ready_out <= 1'b0;
                        state              <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (rd_q) begin
                        sram_oe_n_out <= 1'b0;
                        wait_cnt      <= CNT_W'(RD_WAIT - 1);
                        state         <= S_READ;
                    end else begin
                        sram_we_n_out <= 1'b0;
                        wait_cnt      <= CNT_W'(WR_WAIT - 1);
                        state         <= S_WRITE;
                    end
                end
                S_READ: begin
                    if (wait_cnt == '0) begin
                        sram_oe_n_out      <= 1'b1;
                        sram_ce_n_out      <= 1'b1;
                        sram_lb_n_out      <= 1'b1;
                        sram_ub_n_out      <= 1'b1;
                        host.rsp_rdata_out <= lane_q ? sram_data_io[15:8] : sram_data_io[7:0];
                        host.rsp_valid_out <= 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
                        state              <= S_TURN;
`else
                        host.req_ready_out <= 1'b1;
                        state              <= S_IDLE;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (wait_cnt == '0) begin
                        sram_we_n_out <= 1'b1;
                        state         <= S_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    sram_ce_n_out      <= 1'b1;
                    sram_lb_n_out      <= 1'b1;
                    sram_ub_n_out      <= 1'b1;
                    drive_q            <= 1'b0;
                    host.rsp_valid_out <= 1'b1;
                    host.req_ready_out <= 1'b1;
                    state              <= S_IDLE;
                end
`ifdef SRAM_CTRL_TURNAROUND_EN
                S_TURN: begin
                    host.req_ready_out <= 1'b1;
                    state              <= S_IDLE;
                end
`endif
                default: begin
                    host.req_ready_out <= 1'b1;
                    state              <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_ctrl_param.sv
// Self-checking bench for sram_ctrl_param: directed pin traces, a vector table,
// random accesses against a byte-array reference model, reset abort, and a
// second instance with RD_WAIT=4 / WR_WAIT=1.
`timescale 1ns/1ps
module tb_sram_ctrl_param;
    localparam int unsigned ADDR_W  = 19;
    localparam int          RD_LAT  = 3;   // 1 setup + 2 read cycles
    localparam int          WR_LAT  = 4;   // 1 setup + 2 write + 1 hold
`ifdef SRAM_CTRL_TURNAROUND_EN
    localparam bit TURN_EN = 1'b1;
`else
    localparam bit TURN_EN = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk_in = ~clk_in;

    // Main instance with default timing
    sram_ctrl_param_if #(.ADDR_W(ADDR_W)) h();
    logic [ADDR_W-2:0] sram_addr;
    wire  [15:0]       sram_data;
    logic ce_n, oe_n, we_n, lb_n, ub_n;

    sram_ctrl_param #(.ADDR_W(ADDR_W), .RD_WAIT(2), .WR_WAIT(2)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .host(h),
        .sram_addr_out(sram_addr), .sram_data_io(sram_data),
        .sram_ce_n_out(ce_n), .sram_oe_n_out(oe_n), .sram_we_n_out(we_n),
        .sram_lb_n_out(lb_n), .sram_ub_n_out(ub_n)
    );

    // Second instance with slow reads, fast writes
    sram_ctrl_param_if #(.ADDR_W(ADDR_W)) h2();
    logic [ADDR_W-2:0] sram_addr2;
    wire  [15:0]       sram_data2;
    logic ce2_n, oe2_n, we2_n, lb2_n, ub2_n;

    sram_ctrl_param #(.ADDR_W(ADDR_W), .RD_WAIT(4), .WR_WAIT(1)) u_dut2 (
        .clk_in(clk_in), .rst_in(rst_in), .host(h2),
        .sram_addr_out(sram_addr2), .sram_data_io(sram_data2),
        .sram_ce_n_out(ce2_n), .sram_oe_n_out(oe2_n), .sram_we_n_out(we2_n),
        .sram_lb_n_out(lb2_n), .sram_ub_n_out(ub2_n)
    );

    // Asynchronous SRAM device model (1k words)
    logic [15:0] sram_mem [0:1023];
    assign sram_data = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr[9:0]] : 16'hzzzz;
    always @(negedge clk_in) begin
        if (rst_in && !ce_n && !we_n) begin
            if (!lb_n) sram_mem[sram_addr[9:0]][7:0]  <= sram_data[7:0];
            if (!ub_n) sram_mem[sram_addr[9:0]][15:8] <= sram_data[15:8];
        end
    end

    // Reference model: host-visible byte memory
    logic [7:0] ref_mem [0:255];

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wd;
        logic [7:0]        exp_rd;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One access on the main instance; starts and ends at a negedge.
    task automatic do_access(input logic rw, input logic [ADDR_W-1:0] addr, input logic [7:0] wd,
                             output logic [7:0] rd, output int lat);
        int w;
        int n;
        w = 0;
        while (!h.req_ready_out && w < 50) begin
            @(negedge clk_in);
            w++;
        end
        if (w >= 50) chk("ready_timeout", 32'd0, 32'd1);
        h.req_rw_in    = rw;
        h.req_addr_in  = addr;
        h.req_wdata_in = wd;
        h.req_valid_in = 1'b1;
        @(posedge clk_in);
        #1 h.req_valid_in = 1'b0;
        h.req_wdata_in = 8'hEE;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!h.rsp_valid_out && n < 50);
        if (n >= 50) chk("rsp_timeout", 32'd0, 32'd1);
        lat = n - 1;
        rd  = h.rsp_rdata_out;
        @(negedge clk_in);
        chk("rsp_single_pulse", 32'(h.rsp_valid_out), 32'd0);
    endtask

    // Write with per-cycle pin checks of SETUP / WRITE / HOLD / response.
    task automatic write_trace(input logic [ADDR_W-1:0] addr, input logic [7:0] wd);
        logic [15:0] exp_bus;
        exp_bus = addr[0] ? {wd, 8'h00} : {8'h00, wd};
        h.req_rw_in = 1'b0; h.req_addr_in = addr; h.req_wdata_in = wd; h.req_valid_in = 1'b1;
        @(posedge clk_in);
        #1 h.req_valid_in = 1'b0;
        h.req_addr_in = '0;
        @(negedge clk_in);
        chk("setup_ce_n", 32'(ce_n), 32'd0);
        chk("setup_we_n", 32'(we_n), 32'd1);
        chk("setup_oe_n", 32'(oe_n), 32'd1);
        chk("setup_lb_n", 32'(lb_n), 32'(addr[0]));
        chk("setup_ub_n", 32'(ub_n), 32'(!addr[0]));
        chk("setup_bus", 32'(sram_data), 32'(exp_bus));
        chk("setup_addr", 32'(sram_addr), 32'(addr >> 1));
        @(negedge clk_in);
        chk("write1_we_n", 32'(we_n), 32'd0);
        @(negedge clk_in);
        chk("write2_we_n", 32'(we_n), 32'd0);
        chk("write2_bus", 32'(sram_data), 32'(exp_bus));
        @(negedge clk_in);
        chk("hold_we_n", 32'(we_n), 32'd1);
        chk("hold_ce_n", 32'(ce_n), 32'd0);
        chk("hold_bus", 32'(sram_data), 32'(exp_bus));
        chk("hold_rsp", 32'(h.rsp_valid_out), 32'd0);
        @(negedge clk_in);
        chk("wr_rsp_valid", 32'(h.rsp_valid_out), 32'd1);
        chk("wr_rsp_ready", 32'(h.req_ready_out), 32'd1);
        chk("wr_rsp_ce_n", 32'(ce_n), 32'd1);
        ref_mem[addr[7:0]] = wd;
        @(negedge clk_in);
        chk("wr_rsp_pulse", 32'(h.rsp_valid_out), 32'd0);
    endtask

    // Access on the slow-read instance; counts strobe-low cycles and latency.
    task automatic measure2(input logic rw, output int lo_cnt, output int lat);
        int n;
        h2.req_rw_in = rw; h2.req_addr_in = 19'h4; h2.req_wdata_in = 8'h11; h2.req_valid_in = 1'b1;
        @(posedge clk_in);
        #1 h2.req_valid_in = 1'b0;
        lo_cnt = 0;
        lat    = -1;
        for (n = 1; n <= 12; n++) begin
            @(negedge clk_in);
            if ((rw && !oe2_n) || (!rw && !we2_n)) lo_cnt++;
            if (h2.rsp_valid_out && lat < 0) lat = n - 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int         lat;
        int         n;
        int         lo;
        int         seen;
        logic       rw;
        logic [7:0] a;
        logic [7:0] wd;

        for (int i = 0; i < 1024; i++) sram_mem[i] = 16'h0000;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        h.req_valid_in  = 1'b0; h.req_rw_in  = 1'b0; h.req_addr_in  = '0; h.req_wdata_in  = '0;
        h2.req_valid_in = 1'b0; h2.req_rw_in = 1'b0; h2.req_addr_in = '0; h2.req_wdata_in = '0;

        // Vector table: {rw, addr, wdata, expected read byte}
        vecs[0] = '{1'b1, 19'h00005, 8'h00, 8'h3C};
        vecs[1] = '{1'b1, 19'h00004, 8'h00, 8'hA5};
        vecs[2] = '{1'b0, 19'h00010, 8'h77, 8'h00};
        vecs[3] = '{1'b1, 19'h00010, 8'h00, 8'h77};
        vecs[4] = '{1'b1, 19'h00011, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 19'h00011, 8'hC3, 8'h00};
        vecs[6] = '{1'b1, 19'h00010, 8'h00, 8'h77};
        vecs[7] = '{1'b1, 19'h00011, 8'h00, 8'hC3};

        // Reset values
        #12;
        chk("rst_ce_n", 32'(ce_n), 32'd1);
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_we_n", 32'(we_n), 32'd1);
        chk("rst_lanes", 32'({lb_n, ub_n}), 32'd3);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_rsp_valid", 32'(h.rsp_valid_out), 32'd0);
        chk("rst_rdata", 32'(h.rsp_rdata_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rst_ready", 32'(h.req_ready_out), 32'd1);

        // Directed lane writes with pin traces
        write_trace(19'h00004, 8'hA5);
        write_trace(19'h00005, 8'h3C);

        // Vector table
        foreach (vecs[i]) begin
            do_access(vecs[i].rw, vecs[i].addr, vecs[i].wd, rd, lat);
            if (vecs[i].rw) begin
                chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
                chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(RD_LAT));
            end else begin
                ref_mem[vecs[i].addr[7:0]] = vecs[i].wd;
                chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(WR_LAT));
            end
        end

        // Back-to-back reads with valid held high
        h.req_rw_in = 1'b1; h.req_addr_in = 19'h00004; h.req_valid_in = 1'b1;
        @(posedge clk_in);
        #1 h.req_addr_in = 19'h00005;
        n = 0;
        do begin @(negedge clk_in); n++; end while (!h.rsp_valid_out && n < 50);
        chk("b2b_first_lat", 32'(n - 1), 32'(RD_LAT));
        chk("b2b_first_rdata", 32'(h.rsp_rdata_out), 32'hA5);
        chk("b2b_ready_on_rsp", 32'(h.req_ready_out), TURN_EN ? 32'd0 : 32'd1);
        n = 0;
        while (!h.req_ready_out && n < 50) begin @(negedge clk_in); n++; end
        chk("b2b_turn_gap", 32'(n), TURN_EN ? 32'd1 : 32'd0);
        @(posedge clk_in);
        #1 h.req_valid_in = 1'b0;
        n = 0;
        do begin @(negedge clk_in); n++; end while (!h.rsp_valid_out && n < 50);
        chk("b2b_second_lat", 32'(n - 1), 32'(RD_LAT));
        chk("b2b_second_rdata", 32'(h.rsp_rdata_out), 32'h3C);
        @(negedge clk_in);
        chk("b2b_pulse", 32'(h.rsp_valid_out), 32'd0);
        while (!h.req_ready_out) @(negedge clk_in);

        // Read followed by write: ready gap after read response, idle strobes
        h.req_rw_in = 1'b1; h.req_addr_in = 19'h00004; h.req_valid_in = 1'b1;
        @(posedge clk_in);
        #1 h.req_valid_in = 1'b0;
        n = 0;
        do begin @(negedge clk_in); n++; end while (!h.rsp_valid_out && n < 50);
        chk("turn_ready_rsp", 32'(h.req_ready_out), TURN_EN ? 32'd0 : 32'd1);
        chk("turn_ce_n", 32'(ce_n), 32'd1);
        chk("turn_oe_n", 32'(oe_n), 32'd1);
        @(negedge clk_in);
        chk("turn_ready_next", 32'(h.req_ready_out), 32'd1);
        do_access(1'b0, 19'h00020, 8'h5E, rd, lat);
        ref_mem[8'h20] = 8'h5E;
        chk("turn_write_lat", 32'(lat), 32'(WR_LAT));

        // Random accesses against the reference model
        for (int i = 0; i < 150; i++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 255));
            wd = 8'($urandom);
            do_access(rw, ADDR_W'(a), wd, rd, lat);
            if (rw) begin
                chk("rand_rdata", 32'(rd), 32'(ref_mem[a]));
                chk("rand_rd_lat", 32'(lat), 32'(RD_LAT));
            end else begin
                ref_mem[a] = wd;
                chk("rand_wr_lat", 32'(lat), 32'(WR_LAT));
            end
        end

        // Reset asserted in the middle of a write
        h.req_rw_in = 1'b0; h.req_addr_in = 19'h00301; h.req_wdata_in = 8'h5A; h.req_valid_in = 1'b1;
        @(posedge clk_in);
        #1 h.req_valid_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("abort_in_write", 32'(we_n), 32'd0);
        chk("abort_bus_driven", 32'(sram_data), 32'h5A00);
        #2 rst_in = 1'b0;
        #1;
        chk("abort_ce_n", 32'(ce_n), 32'd1);
        chk("abort_we_n", 32'(we_n), 32'd1);
        chk("abort_oe_n", 32'(oe_n), 32'd1);
        chk("abort_lanes", 32'({lb_n, ub_n}), 32'd3);
        chk("abort_addr", 32'(sram_addr), 32'd0);
        chk("abort_bus_released", 32'(sram_data !== 16'h5A00), 32'd1);
        chk("abort_rsp", 32'(h.rsp_valid_out), 32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            if (h.rsp_valid_out) seen++;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        chk("abort_ready", 32'(h.req_ready_out), 32'd1);
        chk("abort_rdata_cleared", 32'(h.rsp_rdata_out), 32'd0);

        // Main instance still functional after abort
        do_access(1'b1, 19'h00004, 8'h00, rd, lat);
        chk("post_abort_rdata", 32'(rd), 32'hA5);

        // RD_WAIT=4 / WR_WAIT=1 instance
        measure2(1'b1, lo, lat);
        chk("slow_oe_low_cycles", 32'(lo), 32'd4);
        chk("slow_rd_lat", 32'(lat), 32'd5);
        measure2(1'b0, lo, lat);
        chk("slow_we_low_cycles", 32'(lo), 32'd1);
        chk("slow_wr_lat", 32'(lat), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
